// File: rtl/dmem_wb_pkg.sv
// Shared types and helpers for the core data-port to Wishbone bridge.
package dmem_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam int SEL_MAX_W = 128;
    localparam logic [SEL_MAX_W-1:0] SEL_ALL = '1;

    // Wide enough to hold TIMEOUT_CYCLES; never narrower than one bit.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_wb_timeout.sv
// Bus-cycle watchdog: counts cycles while enabled, pulses expired on the last allowed cycle.
module dmem_wb_timeout
    import dmem_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = tmo_cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owner leaves BUS on this pulse, so it lasts a single cycle.
    assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_wb_bridge.sv
// Core split data-memory port to Wishbone B4 classic master, one outstanding
// transaction, with an optional bus timeout that reports an error to the core.
module dmem_wb_bridge
    import dmem_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   mem_d_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_d_data_wr_i,
    input  logic                    mem_d_rd_i,
    input  logic [DATA_WIDTH/8-1:0] mem_d_wr_i,
    output logic                    mem_d_accept_o,
    output logic                    mem_d_ack_o,
    output logic [DATA_WIDTH-1:0]   mem_d_data_rd_o,
    output logic                    mem_d_error_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [STRB_W-1:0]       sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    req;
    logic                    expired;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_tmo
            dmem_wb_timeout #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_timeout (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .clr_i    (state_q == IDLE),
                .en_i     (state_q == BUS),
                .expired_o(expired)
            );
        end else begin : g_no_tmo
            assign expired = 1'b0;
        end
    endgenerate

    assign req = mem_d_rd_i || (|mem_d_wr_i);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = |mem_d_wr_i;
                    sel_d   = (|mem_d_wr_i) ? mem_d_wr_i : SEL_ALL[STRB_W-1:0];
                    adr_d   = mem_d_addr_i;
                    dat_d   = mem_d_data_wr_i;
                end
            end
            BUS: begin
                // Error wins over a simultaneous ack; timeout only when the slave is silent.
                if (wb_err_i || wb_ack_i || expired) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    ack_d   = 1'b1;
                    if (wb_err_i || !wb_ack_i) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_d_accept_o  = (state_q == IDLE) && !rst_i;
    assign mem_d_ack_o     = ack_q;
    assign mem_d_error_o   = err_q;
    assign mem_d_data_rd_o = rdata_q;
    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = cyc_q;
    assign wb_we_o         = we_q;
    assign wb_sel_o        = sel_q;
    assign wb_adr_o        = adr_q;
    assign wb_dat_o        = dat_q;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Directed bench for dmem_wb_bridge; responses checked by a scoreboard monitor on mem_d_ack_o.
module tb_dmem_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] mem_d_addr_i = '0;
    logic [31:0] mem_d_data_wr_i = '0;
    logic        mem_d_rd_i = 1'b0;
    logic [3:0]  mem_d_wr_i = '0;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_error_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    dmem_wb_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_d_addr_i   (mem_d_addr_i),
        .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i     (mem_d_rd_i),
        .mem_d_wr_i     (mem_d_wr_i),
        .mem_d_accept_o (mem_d_accept_o),
        .mem_d_ack_o    (mem_d_ack_o),
        .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_error_o  (mem_d_error_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_sel_o       (wb_sel_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc_n = 0;
    int    ack_cnt = 0;
    int    last_ack_cyc = -100;
    int    prev_ack_cyc = -100;

    always @(posedge clk_i) cyc_n++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic err);
        resp_t r;
        r.data = data;
        r.err  = err;
        exp_q.push_back(r);
    endtask

    always @(negedge clk_i) begin
        resp_t r;
        if (mem_d_ack_o) begin
            ack_cnt++;
            prev_ack_cyc = last_ack_cyc;
            last_ack_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with no pending response (t=%0t)", $time);
            end else begin
                r = exp_q.pop_front();
                check("resp_data", mem_d_data_rd_o, r.data);
                check("resp_err", mem_d_error_o, r.err);
            end
        end else begin
            check("err_without_ack", mem_d_error_o, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_accept", mem_d_accept_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_ack", mem_d_ack_o, 0);
        check("rst_rdata", mem_d_data_rd_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_accept", mem_d_accept_o, 1);

        // Zero-wait read
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h0000_0100; push(32'hDEAD_BEEF, 1'b0);
        @(negedge clk_i);
        mem_d_rd_i = 1'b0;
        check("rd_cyc", wb_cyc_o, 1);
        check("rd_stb", wb_stb_o, 1);
        check("rd_adr", wb_adr_o, 32'h100);
        check("rd_we", wb_we_o, 0);
        check("rd_sel", wb_sel_o, 4'hF);
        check("rd_accept_busy", mem_d_accept_o, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("rd_ack_lat2", mem_d_ack_o, 1);
        check("rd_cyc_drop", wb_cyc_o, 0);
        @(negedge clk_i);
        check("rd_ack_pulse", mem_d_ack_o, 0);
        check("rd_hold", mem_d_data_rd_o, 32'hDEAD_BEEF);

        // Byte write, 3 wait states
        mem_d_wr_i = 4'b0100; mem_d_data_wr_i = 32'h00AB_0000; mem_d_addr_i = 32'h204;
        push(32'hDEAD_BEEF, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                mem_d_wr_i = '0;
                check("wr_sel", wb_sel_o, 4'b0100);
                check("wr_we", wb_we_o, 1);
                check("wr_dat", wb_dat_o, 32'h00AB_0000);
                check("wr_adr", wb_adr_o, 32'h204);
            end
            check("wr_cyc_held", wb_cyc_o, 1);
            check("wr_stb_held", wb_stb_o, 1);
            check("wr_no_early_ack", mem_d_ack_o, 0);
            if (i == 4) wb_ack_i = 1'b1;
        end
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        check("wr_ack", mem_d_ack_o, 1);
        check("wr_cyc_drop", wb_cyc_o, 0);
        @(negedge clk_i);
        check("wr_ack_pulse", mem_d_ack_o, 0);

        // Back-to-back reads
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h10; push(32'h1111_1111, 1'b0);
        @(negedge clk_i);
        mem_d_rd_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        check("b2b_ack1", mem_d_ack_o, 1);
        check("b2b_accept_in_ack", mem_d_accept_o, 1);
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h14; push(32'h2222_2222, 1'b0);
        @(negedge clk_i);
        mem_d_rd_i = 1'b0;
        check("b2b_cyc2", wb_cyc_o, 1);
        check("b2b_adr2", wb_adr_o, 32'h14);
        wb_ack_i = 1'b1; wb_dat_i = 32'h2222_2222;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("b2b_ack2", mem_d_ack_o, 1);
        @(negedge clk_i);
        check("b2b_ack_gap", last_ack_cyc - prev_ack_cyc, 2);

        // Timeout with silent slave
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h300; push(32'h0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_i);
            mem_d_rd_i = 1'b0;
            check("tmo_cyc_held", wb_cyc_o, 1);
        end
        @(negedge clk_i);
        check("tmo_cyc_drop", wb_cyc_o, 0);
        check("tmo_ack", mem_d_ack_o, 1);
        check("tmo_rdata_zero", mem_d_data_rd_o, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk_i);
            check("stray_no_ack", mem_d_ack_o, 0);
            check("stray_no_cyc", wb_cyc_o, 0);
            check("stray_rdata", mem_d_data_rd_o, 0);
        end
        wb_ack_i = 1'b0; wb_dat_i = '0;

        // ack+err together: err wins
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h400; push(32'h0, 1'b1);
        @(negedge clk_i);
        mem_d_rd_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        check("err_ack", mem_d_ack_o, 1);
        // rd and wr together behave as a write
        mem_d_rd_i = 1'b1; mem_d_wr_i = 4'hF; mem_d_addr_i = 32'h404;
        mem_d_data_wr_i = 32'hCAFE_F00D; push(32'h0, 1'b0);
        @(negedge clk_i);
        mem_d_rd_i = 1'b0; mem_d_wr_i = '0;
        check("rdwr_we", wb_we_o, 1);
        check("rdwr_sel", wb_sel_o, 4'hF);
        check("rdwr_dat", wb_dat_o, 32'hCAFE_F00D);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        check("rdwr_ack", mem_d_ack_o, 1);

        // Reset during a wait state
        @(negedge clk_i);
        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h500;
        @(negedge clk_i);
        mem_d_rd_i = 1'b0;
        check("mid_rst_cyc_before", wb_cyc_o, 1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_ack", mem_d_ack_o, 0);
        check("mid_rst_accept", mem_d_accept_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            check("post_rst_no_ack", mem_d_ack_o, 0);
            check("post_rst_no_cyc", wb_cyc_o, 0);
        end

        check("resp_queue_drained", exp_q.size(), 0);
        check("ack_total", ack_cnt, 7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_wb_bridge.md
Name: dmem_wb_bridge

Overview:
- Converts the core's split data-memory port (rd/wr strobes, accept, one-cycle ack) into a Wishbone B4 classic master.
- Sits between the core's mem_d_* port and the controller's data_mem_* Wishbone slave, replacing ad-hoc glue and response registers in the top.
- Supports one outstanding transaction, byte-lane writes, and a bus timeout that returns an error instead of hanging the core.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 wide.
- TIMEOUT_CYCLES, 255, maximum cycles in BUS before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mem_d_addr_i  in  ADDR_WIDTH  core request address.
- mem_d_data_wr_i  in  DATA_WIDTH  core write data.
- mem_d_rd_i  in  1  read request.
- mem_d_wr_i  in  DATA_WIDTH/8  write byte strobes; nonzero means write request.
- mem_d_accept_o  out  1  bridge can take a request this cycle.
- mem_d_ack_o  out  1  one-cycle response pulse.
- mem_d_data_rd_o  out  DATA_WIDTH  read data, valid with ack.
- mem_d_error_o  out  1  error flag, valid with ack.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  DATA_WIDTH/8  Wishbone byte select.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset: one clock, clk_i; rst_i is asynchronous and active-high.
  - While rst_i=1, state=IDLE and all registered outputs are 0: cyc, stb, we, sel, adr, dat_o, ack, error, data_rd, timeout counter.
  - mem_d_accept_o = (state==IDLE) && !rst_i, combinational.
- States:
  - IDLE: accept=1.
    - At a clock edge with accept=1 and (mem_d_rd_i || mem_d_wr_i!=0), latch the request and go to BUS:
      - adr <= addr; dat_o <= data_wr.
      - we <= (wr!=0).
      - sel <= wr if write, else all-ones.
    - With no request, stay in IDLE.
  - BUS: cyc=stb=1 and held stable until termination. Accept=0.
    - The timeout counter starts at 0 on entry and increments each cycle in BUS.
    - Termination at an edge with wb_err_i=1 sets error=1 and data_rd=0.
    - Termination at an edge with wb_ack_i=1 (and no err) sets error=0 and data_rd <= wb_dat_i for a read; data_rd is unchanged for a write.
    - Termination when TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 with no ack/err sets error=1 and data_rd=0.
    - On any termination: cyc/stb/we/sel drop to 0 at that edge, ack <= 1, state -> IDLE.
- Response: mem_d_ack_o is high exactly one cycle, the cycle after termination.
  - That cycle is also IDLE, so accept=1; a back-to-back request is taken at that edge.
- mem_d_data_rd_o holds the last read value between acks. mem_d_error_o is 0 except in the ack cycle of a failed transaction.
- Latency: request at edge N gives cyc=1 during cycle N+1. For a zero-wait slave (ack at edge N+1), ack_o is high during cycle N+2. Minimum 2 cycles request-to-ack.
- Simultaneous rd and wr!=0: treated as a write; rd is ignored.
- wb_ack_i and wb_err_i together: err wins.
- ack/err arriving in IDLE (stray): ignored, with no state or output change.
- Requests presented while accept=0 are not latched. The core holds them until accepted.
- Reset asserted mid-BUS: immediate abort. cyc/stb fall asynchronously, and no ack is generated after reset release.
- Address passes through unmodified; no alignment check.

Decomposition:
- Package dmem_wb_pkg:
  - state encoding: IDLE=1'b0, BUS=1'b1.
  - constant SEL_ALL.
  - localparam helper for the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- One natural sub-module: dmem_wb_timeout.
  - Inputs: clr/en.
  - Output: expired, a single-cycle pulse.
  - Instantiated only when TIMEOUT_CYCLES!=0 (generate).

Test Plan:
- Read, zero-wait: rd=1, addr=0x0000_0100; slave acks next cycle with 0xDEAD_BEEF. Expect:
  - wb_adr=0x100, we=0, sel=4'hF.
  - ack_o high 2 cycles after the request, data_rd=0xDEAD_BEEF, error=0.
- Byte write with 3 wait states: wr=4'b0100, data=0x00AB_0000, addr=0x204. Expect:
  - cyc/stb held 4 cycles, sel=4'b0100, we=1.
  - single ack_o pulse; data_rd unchanged from the prior read.
- Back-to-back: two reads at 0x10, 0x14 with the second presented in the first's ack cycle. Expect the second accepted in that cycle and two ack pulses 2 cycles apart.
- Timeout: TIMEOUT_CYCLES=8, slave never acks. Expect:
  - cyc low after 8 BUS cycles.
  - ack_o=1 with error=1, data_rd=0.
  - a stray wb_ack_i afterwards is ignored.
- Err priority: slave asserts ack and err together on a read. Expect error=1, data_rd=0. Separately, rd and wr=4'hF together produce a write with we=1.
- Reset mid-BUS: assert rst_i between edges during a wait state. Expect cyc/stb/ack low immediately, accept=0 during reset, and no ack_o after release.
